// File: rtl/pong_pkg.sv
// Shared types, widths and defaults for the paddle sensor sequencer.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      BACKOFF = 2'd2
   } paddle_state_t;

   localparam int PADDLE_POS_W     = 10;
   localparam int RANGE_W          = 16;

   localparam int DEF_RANGE_MIN    = 45;
   localparam int DEF_POS_MAX      = 420;
   localparam int DEF_RETRY_CYCLES = 1_000_000;

   // Range in mm to paddle position: offset, halve, clamp, truncate.
   function automatic logic [PADDLE_POS_W-1:0] range_to_pos(
      input logic [RANGE_W-1:0] range,
      input logic [RANGE_W-1:0] range_min,
      input logic [14:0]        pos_max
   );
      logic [RANGE_W-1:0] diff;
      logic [14:0]        scaled;
      diff   = range - range_min;
      scaled = diff[RANGE_W-1:1];
      if (range <= range_min) begin
         scaled = '0;
      end else if (scaled > pos_max) begin
         scaled = pos_max;
      end
      return scaled[PADDLE_POS_W-1:0];
   endfunction

endpackage

// File: rtl/paddle_filter.sv
// Range conversion register followed by a power-of-two moving average.
module paddle_filter
   import pong_pkg::*;
#(
   parameter int RANGE_MIN = DEF_RANGE_MIN,
   parameter int POS_MAX   = DEF_POS_MAX,
   parameter int AVG_LOG2  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sample_en,
   input  logic [RANGE_W-1:0]      range,
   input  logic                    clear_valid,
   output logic [PADDLE_POS_W-1:0] position,
   output logic                    position_valid
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = PADDLE_POS_W + AVG_LOG2;
   localparam logic [RANGE_W-1:0] RMIN = RANGE_W'(RANGE_MIN);
   localparam logic [14:0]        PMAX = 15'(POS_MAX);

   logic [PADDLE_POS_W-1:0] conv;
   logic                    pend;
   logic [PADDLE_POS_W-1:0] win [DEPTH];
   logic [SUM_W-1:0]        sum;
   logic [SUM_W-1:0]        sum_next;

   // Stage 1: capture the converted sample on an accepted frame edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conv <= '0;
         pend <= 1'b0;
      end else begin
         pend <= sample_en;
         if (sample_en) begin
            conv <= range_to_pos(range, RMIN, PMAX);
         end
      end
   end

   // New running sum: preload with the first sample, else add newest minus oldest.
   always_comb begin
      sum_next = sum;
      if (!position_valid) begin
         sum_next = SUM_W'(conv) << AVG_LOG2;
      end else begin
         sum_next = sum + SUM_W'(conv) - SUM_W'(win[DEPTH-1]);
      end
   end

   // Stage 2: shift the window, update sum/position; IDLE entry drops validity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            win[i] <= '0;
         end
         sum            <= '0;
         position       <= '0;
         position_valid <= 1'b0;
      end else begin
         if (pend) begin
            win[0] <= conv;
            for (int unsigned i = 1; i < DEPTH; i++) begin
               win[i] <= position_valid ? win[i-1] : conv;
            end
            sum      <= sum_next;
            position <= PADDLE_POS_W'(sum_next >> AVG_LOG2);
         end
         if (clear_valid) begin
            position_valid <= 1'b0;
         end else if (pend) begin
            position_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/paddle_sensor_ctrl.sv
// Driver start/retry sequencer with frame-synchronous filtered paddle position.
module paddle_sensor_ctrl
   import pong_pkg::*;
#(
   parameter int RANGE_MIN    = DEF_RANGE_MIN,
   parameter int POS_MAX      = DEF_POS_MAX,
   parameter int AVG_LOG2     = 2,
   parameter int RETRY_CYCLES = DEF_RETRY_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    vsync,
   output logic                    drv_setup_and_run,
   input  logic                    drv_error,
   input  logic [RANGE_W-1:0]      drv_range,
   output logic [PADDLE_POS_W-1:0] position,
   output logic                    position_valid,
   output logic                    sensor_ok,
   output logic [3:0]              retry_count
);

   localparam int CNT_W = $clog2(RETRY_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RETRY_CYCLES - 1);

   paddle_state_t   state;
   paddle_state_t   state_next;
   logic [CNT_W-1:0] cnt;
   logic            vs_q;
   logic            frame_edge;
   logic            sample_en;
   logic            clear_valid;
   logic            err_hit;

   assign frame_edge  = vs_q & ~vsync;
   assign err_hit     = (state == RUN) && drv_error;
   assign sample_en   = frame_edge && (state == RUN) && !drv_error;
   assign clear_valid = (state_next == IDLE);
   assign sensor_ok   = (state == RUN) && position_valid;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and driver enable; dropping run overrides every transition.
   always_comb begin
      state_next        = state;
      drv_setup_and_run = 1'b0;
      case (state)
         IDLE: begin
            if (run) state_next = RUN;
         end
         RUN: begin
            drv_setup_and_run = 1'b1;
            if (drv_error) state_next = BACKOFF;
         end
         BACKOFF: begin
            if (cnt == '0) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
      if (!run) state_next = IDLE;
   end

   // Back-off counter: loaded on error, counts down in BACKOFF, cleared into IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (state_next == IDLE) begin
         cnt <= '0;
      end else if (err_hit) begin
         cnt <= CNT_LOAD;
      end else if (state == BACKOFF && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Saturating driver error count; counts even when run drops in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retry_count <= '0;
      end else if (err_hit && retry_count != 4'hF) begin
         retry_count <= retry_count + 4'd1;
      end
   end

   // vsync delay for falling-edge detection; idles high like the inactive sync.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_q <= 1'b1;
      end else begin
         vs_q <= vsync;
      end
   end

   paddle_filter #(
      .RANGE_MIN (RANGE_MIN),
      .POS_MAX   (POS_MAX),
      .AVG_LOG2  (AVG_LOG2)
   ) u_filter (
      .clk            (clk),
      .reset          (reset),
      .sample_en      (sample_en),
      .range          (drv_range),
      .clear_valid    (clear_valid),
      .position       (position),
      .position_valid (position_valid)
   );

endmodule
